// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI counter receiver
package spi_pkg;

    typedef enum logic [0:0] {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } rx_pair_state_e;

    localparam int unsigned SPI_BYTE_BITS = 8;
    localparam int unsigned COUNTER_MAX   = 9999;

endpackage

// File: rtl/spi_slave_byte_rx.sv
// rtl/spi_slave_byte_rx.sv - synchronizes SPI pins and shifts in mode-0 bytes MSB first
module spi_slave_byte_rx
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       short_byte,
    output logic       ss_high
);

    // Stage 0/1 form the synchronizer, stage 2 is the edge-detect history.
    // mosi gets the same 2-stage depth so it lines up with the synced sclk.
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] ss_sync_q, ss_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_valid_q, byte_valid_d;
    logic       short_byte_q, short_byte_d;

    logic sclk_rise;
    logic ss_fall;
    logic ss_rise;
    logic ss_low;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    assign ss_low    = ~ss_sync_q[1];

    // Next-state for synchronizers, shifter and bit counter
    always_comb begin
        sclk_sync_d  = {sclk_sync_q[1:0], sclk};
        ss_sync_d    = {ss_sync_q[1:0], ss};
        mosi_sync_d  = {mosi_sync_q[0], mosi};
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        short_byte_d = 1'b0;

        if (ss_fall) begin
            bit_cnt_d = 3'd0;
        end else if (ss_rise) begin
            // A select window closing mid-byte throws the partial byte away.
            if (bit_cnt_q != 3'd0) begin
                short_byte_d = 1'b1;
            end
            bit_cnt_d = 3'd0;
        end else if (ss_low && sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_sync_q[1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(SPI_BYTE_BITS - 1)) begin
                byte_d       = {shift_q[6:0], mosi_sync_q[1]};
                byte_valid_d = 1'b1;
            end
        end
    end

    // State registers; ss idles high so the synchronizer resets to 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q  <= 3'b000;
            ss_sync_q    <= 3'b111;
            mosi_sync_q  <= 2'b00;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            short_byte_q <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            ss_sync_q    <= ss_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            short_byte_q <= short_byte_d;
        end
    end

    assign byte_data  = byte_q;
    assign byte_valid = byte_valid_q;
    assign short_byte = short_byte_q;
    assign ss_high    = ss_sync_q[1];

endmodule

// File: rtl/spi_counter_receiver.sv
// rtl/spi_counter_receiver.sv - pairs SPI bytes into 16-bit counter values with fault flags
module spi_counter_receiver
    import spi_pkg::*;
#(
    parameter int unsigned GAP_TIMEOUT = 1000,
    parameter int unsigned MAX_VALUE   = COUNTER_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss,
    output logic [15:0] rx_value,
    output logic        rx_valid,
    output logic        range_err,
    output logic        frame_err
);

    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       short_byte;
    logic       ss_high;

    spi_slave_byte_rx u_byte_rx (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss        (ss),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .short_byte(short_byte),
        .ss_high   (ss_high)
    );

    rx_pair_state_e state_q, state_d;
    logic [7:0]       upper_q, upper_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      rx_value_q, rx_value_d;
    logic             rx_valid_q, rx_valid_d;
    logic             range_err_q, range_err_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      pair_value;

    assign pair_value = {upper_q, byte_data};

    // Pairing FSM: a short byte outranks everything and collapses with a
    // simultaneous gap timeout into one frame_err pulse.
    always_comb begin
        state_d     = state_q;
        upper_d     = upper_q;
        gap_d       = gap_q;
        rx_value_d  = rx_value_q;
        rx_valid_d  = 1'b0;
        range_err_d = range_err_q;
        frame_err_d = 1'b0;

        if (short_byte) begin
            frame_err_d = 1'b1;
            gap_d       = '0;
            state_d     = WAIT_HI;
        end else begin
            case (state_q)
                WAIT_HI: begin
                    if (byte_valid) begin
                        upper_d = byte_data;
                        gap_d   = '0;
                        state_d = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (byte_valid) begin
                        rx_value_d  = pair_value;
                        rx_valid_d  = 1'b1;
                        range_err_d = (32'(pair_value) > MAX_VALUE);
                        state_d     = WAIT_HI;
                    end else if (ss_high) begin
                        if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
                            frame_err_d = 1'b1;
                            gap_d       = '0;
                            state_d     = WAIT_HI;
                        end else begin
                            gap_d = gap_q + 1'b1;
                        end
                    end else begin
                        gap_d = '0;
                    end
                end
                default: state_d = WAIT_HI;
            endcase
        end
    end

    // Pairing state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_HI;
            upper_q     <= 8'h00;
            gap_q       <= '0;
            rx_value_q  <= 16'h0000;
            rx_valid_q  <= 1'b0;
            range_err_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            upper_q     <= upper_d;
            gap_q       <= gap_d;
            rx_value_q  <= rx_value_d;
            rx_valid_q  <= rx_valid_d;
            range_err_q <= range_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_value  = rx_value_q;
    assign rx_valid  = rx_valid_q;
    assign range_err = range_err_q;
    assign frame_err = frame_err_q;

endmodule
